// File: rtl/bus_mem_if.sv
// CPU memory bus between a master (core or bench) and a memory responder.
// Latency: none. This is wiring only.
// Backpressure: the master holds req and its qualifiers until ready; ready and err pulse for one cycle.
interface bus_mem_if;
  logic        req;
  logic        write;
  logic        seq;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (
    output req, write, seq, size, addr, wdata,
    input  rdata, ready, err
  );

  modport slave (
    input  req, write, seq, size, addr, wdata,
    output rdata, ready, err
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Work-RAM responder for the CPU bus: byte/half/word access, misaligned-word read rotation, N/S wait states.
// Latency: ready in cycle 1+W after req is seen in IDLE (W = WAIT_S if seq else WAIT_N); rdata is registered.
// Backpressure: the request stalls in WAIT until the count expires; dropping req in WAIT aborts it with no side effects.
module bus_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int unsigned WAIT_N      = 2,
  parameter int unsigned WAIT_S      = 0
) (
  input  logic      clk,
  input  logic      reset,
  bus_mem_if.slave  bus
);

  localparam int unsigned AW           = $clog2(DEPTH_WORDS);
  localparam logic [63:0] REGION_BYTES = 64'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_N        = 4'(WAIT_N);
  localparam logic [3:0]  CNT_S        = 4'(WAIT_S);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Qualifiers captured when the request is accepted in IDLE
  logic        lat_write;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        ready_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Qualifiers of the transfer being decided this cycle: live bus in IDLE, latched copy afterwards
  logic        cur_write;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic [3:0]  wait_sel;
  logic [63:0] offset;
  logic        in_range;
  logic        bad;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic [4:0]  lane_sh;
  logic [31:0] mem_word;
  logic [31:0] shr_word;
  logic [31:0] read_val;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] new_word;
  logic        go_resp;
  logic        mem_we;

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  // Select which copy of the qualifiers the datapath decodes
  always_comb begin
    cur_write = lat_write;
    cur_size  = lat_size;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == S_IDLE) begin
      cur_write = bus.write;
      cur_size  = bus.size;
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
    end
  end

  // Wait count chosen from the access type of the incoming request
  assign wait_sel = bus.seq ? CNT_S : CNT_N;

  // Region decode done in 64 bits so addresses below the base wrap to a huge offset and miss
  assign offset   = {32'b0, cur_addr} - {32'b0, BASE_ADDR};
  assign in_range = (offset < REGION_BYTES);
  assign bad      = !in_range || (cur_size == 2'b11);
  assign idx      = offset[AW+1:2];
  assign lane     = cur_addr[1:0];
  assign lane_sh  = {lane, 3'b000};
  assign mem_word = mem[idx];
  assign shr_word = mem_word >> lane_sh;

  // Read alignment: byte and half are zero-extended, word is rotated right by the lane
  always_comb begin
    read_val = 32'h0;
    case (cur_size)
      2'b00:   read_val = {24'h0, shr_word[7:0]};
      2'b01:   read_val = cur_addr[1] ? {16'h0, mem_word[31:16]} : {16'h0, mem_word[15:0]};
      2'b10:   read_val = shr_word | (mem_word << (6'd32 - {1'b0, lane_sh}));
      default: read_val = 32'h0;
    endcase
  end

  // Write lane enables and data replicated so every lane sees the right-aligned value
  always_comb begin
    be     = 4'b0000;
    wd_rep = 32'h0;
    case (cur_size)
      2'b00: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        be     = 4'b1111;
        wd_rep = cur_wdata;
      end
      default: begin
        be     = 4'b0000;
        wd_rep = 32'h0;
      end
    endcase
  end

  // Merge enabled lanes over the current word; disabled lanes keep their old bytes
  always_comb begin
    new_word = mem_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        new_word[8*i +: 8] = wd_rep[8*i +: 8];
      end
    end
  end

  // The transfer completes on the edge that raises ready; reset on that edge cancels it
  assign go_resp = reset && bus.req &&
                   (((state == S_IDLE) && (wait_sel == 4'd0)) ||
                    ((state == S_WAIT) && (cnt == 4'd1)));
  assign mem_we  = go_resp && cur_write && !bad;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= new_word;
    end
  end

  // Transfer FSM with registered ready/err/rdata strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      lat_write <= 1'b0;
      lat_size  <= 2'b00;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      if (go_resp) begin
        ready_q <= 1'b1;
        err_q   <= bad;
        rdata_q <= (bad || cur_write) ? 32'h0 : read_val;
      end
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            lat_write <= bus.write;
            lat_size  <= bus.size;
            lat_addr  <= bus.addr;
            lat_wdata <= bus.wdata;
            cnt       <= wait_sel;
            state     <= (wait_sel == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.req) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: expected responses queued at drive time, compared at ready.
// Latency: measured in falling edges from request drive to ready and checked per transfer.
// Backpressure: requests are held until ready; aborts by req drop and by reset are exercised.
module tb_bus_mem_responder;

  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam int unsigned DEPTH  = 1024;
  localparam logic [31:0] REGION = 32'(DEPTH) * 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
    logic [7:0]  lat;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  bus_mem_if bus ();

  bus_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_N      (2),
    .WAIT_S      (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Qualifiers must not move while a request is pending without ready
  logic        prev_pend;
  logic [67:0] q_prev;
  logic [67:0] q_now;
  assign q_now = {bus.write, bus.seq, bus.size, bus.addr, bus.wdata};
  initial prev_pend = 1'b0;
  always @(posedge clk) begin
    if (prev_pend && bus.req && !bus.ready) begin
      checks++;
      assert (q_now === q_prev) else begin
        errors++;
        $error("FAIL qual_stable observed %h expected %h", q_now, q_prev);
      end
    end
    prev_pend = bus.req && !bus.ready && reset;
    q_prev    = q_now;
  end

  // Drive one request and wait (bounded) for its ready; req stays high so a caller may chain
  task automatic xfer(input logic w, input logic s, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                      input int elat, input string tag);
    exp_t e;
    int   n;
    logic got;
    e.rdata    = erd;
    e.err      = eerr;
    e.chk_data = !w;
    e.lat      = 8'(elat);
    sb.push_back(e);
    bus.req   = 1'b1;
    bus.write = w;
    bus.seq   = s;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ready && n < 32);
    got = bus.ready;
    e = sb.pop_front();
    chk({tag, "_ready"}, {31'b0, got}, 32'd1);
    if (got) begin
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
      chk({tag, "_err"}, {31'b0, bus.err}, {31'b0, e.err});
      if (e.chk_data) chk({tag, "_rdata"}, bus.rdata, e.rdata);
    end
  endtask

  // Drop req and confirm the bus stays quiet
  task automatic idle(input int n, input string tag);
    bus.req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_idle_ready"}, {31'b0, bus.ready}, 32'd0);
      chk({tag, "_idle_rdata"}, bus.rdata, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.req   = 1'b0;
    bus.write = 1'b0;
    bus.seq   = 1'b0;
    bus.size  = 2'b00;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.ready}, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    reset = 1'b1;

    // Basic word write then read with N-cycle waits
    xfer(1, 0, 2'b10, BASE, 32'hDEADBEEF, 32'h0, 0, 3, "w_dead");
    idle(1, "t1a");
    xfer(0, 0, 2'b10, BASE, 32'h0, 32'hDEADBEEF, 0, 3, "r_dead");
    idle(1, "t1b");

    // Byte lane write and sub-word reads
    xfer(1, 0, 2'b10, BASE, 32'h11223344, 32'h0, 0, 3, "w_1122");
    idle(1, "t2a");
    xfer(1, 0, 2'b00, BASE + 2, 32'h000000AA, 32'h0, 0, 3, "w_byte");
    idle(1, "t2b");
    xfer(0, 0, 2'b10, BASE, 32'h0, 32'h11AA3344, 0, 3, "r_merge");
    idle(1, "t2c");
    xfer(0, 0, 2'b00, BASE + 3, 32'h0, 32'h00000011, 0, 3, "r_byte3");
    idle(1, "t2d");
    xfer(0, 0, 2'b01, BASE + 3, 32'h0, 32'h000011AA, 0, 3, "r_half3");
    idle(1, "t2e");

    // Misaligned word reads rotate
    xfer(1, 0, 2'b10, BASE, 32'h11223344, 32'h0, 0, 3, "w_rot");
    idle(1, "t3a");
    xfer(0, 0, 2'b10, BASE + 1, 32'h0, 32'h44112233, 0, 3, "r_rot1");
    idle(1, "t3b");
    xfer(0, 0, 2'b10, BASE + 2, 32'h0, 32'h33441122, 0, 3, "r_rot2");
    idle(1, "t3c");

    // Sequential writes chained, halfword write, then back-to-back sequential reads
    xfer(1, 0, 2'b10, BASE + 4,  32'hA0A1A2A3, 32'h0, 0, 3, "w_w1");
    xfer(1, 1, 2'b10, BASE + 8,  32'hB0B1B2B3, 32'h0, 0, 2, "w_w2");
    xfer(1, 1, 2'b10, BASE + 12, 32'hC0C1C2C3, 32'h0, 0, 2, "w_w3");
    idle(1, "t4a");
    xfer(1, 0, 2'b01, BASE + 5, 32'h1234BEEF, 32'h0, 0, 3, "w_half");
    idle(1, "t4b");
    xfer(0, 1, 2'b10, BASE,      32'h0, 32'h11223344, 0, 1, "r_s0");
    xfer(0, 1, 2'b10, BASE + 4,  32'h0, 32'hA0A1BEEF, 0, 2, "r_s1");
    xfer(0, 1, 2'b10, BASE + 8,  32'h0, 32'hB0B1B2B3, 0, 2, "r_s2");
    xfer(0, 1, 2'b10, BASE + 12, 32'h0, 32'hC0C1C2C3, 0, 2, "r_s3");
    idle(2, "t4c");

    // Top byte of the region is legal and does not wrap
    xfer(1, 0, 2'b10, BASE + REGION - 4, 32'h0, 32'h0, 0, 3, "w_top0");
    idle(1, "t5a");
    xfer(1, 0, 2'b00, BASE + REGION - 1, 32'h0000005A, 32'h0, 0, 3, "w_topb");
    idle(1, "t5b");
    xfer(0, 0, 2'b10, BASE + REGION - 4, 32'h0, 32'h5A000000, 0, 3, "r_top");
    idle(1, "t5c");
    xfer(0, 0, 2'b00, BASE + REGION - 1, 32'h0, 32'h0000005A, 0, 3, "r_topb");
    idle(1, "t5d");

    // Errors: below base, past end, reserved size
    xfer(0, 0, 2'b10, BASE - 4, 32'h0, 32'h0, 1, 3, "r_low");
    idle(1, "t5e");
    xfer(0, 0, 2'b10, BASE + REGION, 32'h0, 32'h0, 1, 3, "r_high");
    idle(1, "t5f");
    xfer(0, 0, 2'b11, BASE, 32'h0, 32'h0, 1, 3, "r_sz3");
    idle(1, "t5g");
    xfer(1, 0, 2'b10, BASE + REGION, 32'hFFFFFFFF, 32'h0, 1, 3, "w_high");
    idle(1, "t5h");
    xfer(1, 0, 2'b10, BASE - 4, 32'hFFFFFFFF, 32'h0, 1, 3, "w_low");
    idle(1, "t5i");
    xfer(1, 0, 2'b11, BASE, 32'hFFFFFFFF, 32'h0, 1, 3, "w_sz3");
    idle(1, "t5j");
    xfer(0, 0, 2'b10, BASE, 32'h0, 32'h11223344, 0, 3, "r_w0_kept");
    idle(1, "t5k");
    xfer(0, 0, 2'b10, BASE + REGION - 4, 32'h0, 32'h5A000000, 0, 3, "r_top_kept");
    idle(1, "t5l");

    // Abort by dropping req during the wait
    bus.req   = 1'b1;
    bus.write = 1'b1;
    bus.seq   = 1'b0;
    bus.size  = 2'b10;
    bus.addr  = BASE;
    bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("abort_wait_ready", {31'b0, bus.ready}, 32'd0);
    idle(4, "t6a");
    xfer(0, 0, 2'b10, BASE, 32'h0, 32'h11223344, 0, 3, "r_after_drop");
    idle(1, "t6b");

    // Abort by reset during the wait, req held through it
    bus.req   = 1'b1;
    bus.write = 1'b1;
    bus.seq   = 1'b0;
    bus.size  = 2'b10;
    bus.addr  = BASE;
    bus.wdata = 32'h0BADF00D;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_ready1", {31'b0, bus.ready}, 32'd0);
    @(negedge clk);
    chk("rstw_ready2", {31'b0, bus.ready}, 32'd0);
    reset = 1'b1;
    idle(3, "t6c");
    xfer(0, 0, 2'b10, BASE, 32'h0, 32'h11223344, 0, 3, "r_after_rst");
    idle(1, "t6d");
    xfer(1, 0, 2'b10, BASE + 4, 32'h01020304, 32'h0, 0, 3, "w_after_rst");
    idle(1, "t6e");
    xfer(0, 0, 2'b10, BASE + 4, 32'h0, 32'h01020304, 0, 3, "r_after_rst2");
    idle(1, "t6f");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
